ysyx_25020047_core_ctrl: RTL

//  Multi-cycle sequencer for the NPC core. Owns the FETCH/EXEC/MEM/WB FSM. Drives the IFU fetch request and the IR load.

---
 rtl/ysyx_25020047_pkg.sv | 30 +++
 rtl/ysyx_25020047_wait_timer.sv | 30 +++
 rtl/ysyx_25020047_core_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared types for the NPC multi-cycle sequencer.
// State encodings, inst_type bit positions and error causes.
package ysyx_25020047_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_EBREAK  = 2'd1,
        ERR_ILLEGAL = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam int IT_ADDI   = 0;
    localparam int IT_JALR   = 1;
    localparam int IT_EBREAK = 2;
    localparam int IT_ADD    = 3;
    localparam int IT_LUI    = 4;
    localparam int IT_LW     = 5;
    localparam int IT_LBU    = 6;
    localparam int IT_RSV0   = 7;
    localparam int IT_RSV1   = 8;

endpackage

// File: rtl/ysyx_25020047_wait_timer.sv
// Shared bus-wait counter for the sequencer.
// Flags expiry on the wait cycle that makes the count reach TIMEOUT.
module ysyx_25020047_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // count waiting cycles; clear wins over count
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // this wait cycle is the TIMEOUT-th one
    always_comb begin
        expired = en && (cnt == W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/ysyx_25020047_core_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the NPC core.
// Gates IR, RF and PC writes, issues loads, and halts on faults.
module ysyx_25020047_core_ctrl
    import ysyx_25020047_pkg::*;
#(
    parameter int TYPE_W  = 9,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req,
    input  logic              ifu_rvalid,
    output logic              ir_wen,
    input  logic [TYPE_W-1:0] inst_type,
    input  logic              exu_reg_wen,
    input  logic              exu_read,
    output logic              lsu_req,
    input  logic              lsu_rvalid,
    output logic              rf_wen,
    output logic              pc_wen,
    output logic              halt,
    output logic [1:0]        err,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    state_e state;
    state_e state_next;
    err_e   err_q;
    err_e   err_next;
    logic   load_q;
    logic   load_next;
    logic   type_ok;
    logic   is_load;
    logic   tmr_en;
    logic   tmr_clr;
    logic   tmr_expired;

    // decode legality and load class of the stable IR
    always_comb begin
        type_ok = (inst_type != '0)
               && ((inst_type & (inst_type - TYPE_W'(1))) == '0)
               && !inst_type[IT_RSV0]
               && !inst_type[IT_RSV1];
        is_load = exu_read
               || inst_type[IT_LW]
               || inst_type[IT_LBU];
    end

    // timer runs only while a request is waiting
    always_comb begin
        tmr_en = ((state == ST_FETCH) && !ifu_rvalid)
              || ((state == ST_MEM) && !lsu_rvalid);
        tmr_clr = rst || (state_next != state);
    end

    ysyx_25020047_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // next-state, error cause and strobes
    always_comb begin
        state_next = state;
        err_next   = err_q;
        load_next  = load_q;
        ifu_req    = 1'b0;
        ir_wen     = 1'b0;
        lsu_req    = 1'b0;
        rf_wen     = 1'b0;
        pc_wen     = 1'b0;
        unique case (state)
            ST_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_rvalid) begin
                    ir_wen     = 1'b1;
                    state_next = ST_EXEC;
                end else if (tmr_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (!type_ok) begin
                    err_next   = ERR_ILLEGAL;
                    state_next = ST_HALT;
                end else if (inst_type[IT_EBREAK]) begin
                    err_next   = ERR_EBREAK;
                    state_next = ST_HALT;
                end else if (is_load) begin
                    load_next  = 1'b1;
                    state_next = ST_MEM;
                end else begin
                    load_next  = 1'b0;
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                lsu_req = 1'b1;
                if (lsu_rvalid) begin
                    state_next = ST_WB;
                end else if (tmr_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_HALT;
                end
            end
            ST_WB: begin
                pc_wen     = 1'b1;
                rf_wen     = exu_reg_wen | load_q;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
        if (rst) begin
            ifu_req = 1'b0;
            ir_wen  = 1'b0;
            lsu_req = 1'b0;
            rf_wen  = 1'b0;
            pc_wen  = 1'b0;
        end
    end

    // state, sticky cause and load flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            err_q  <= ERR_NONE;
            load_q <= 1'b0;
        end else begin
            state  <= state_next;
            err_q  <= err_next;
            load_q <= load_next;
        end
    end

    // perf counters freeze once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            if (state != ST_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (state == ST_WB) begin
                inst_cnt <= inst_cnt + CNT_W'(1);
            end
        end
    end

    // registered status views
    always_comb begin
        halt    = (state == ST_HALT);
        err     = err_q;
        state_o = state;
    end

endmodule
